rmw_mem_arbiter: RTL

- Two-requester controller owning a small synchronous-write, combinational-read memory (default 8 x 32).
- Arbitrates between requesters and serializes each access.
- Implements byte-masked writes as a read-modify-write sequence: read old word, merge under mask, write back.
- Sits between client datapaths and the shared scratch memory; the memory array is internal to this block.

---
 rtl/rmw_mem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rmw_mem_arbiter.sv
// Two-requester arbiter in front of an internal scratch memory; byte-masked writes run as read-modify-write.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 always wins ties.
module rmw_mem_arbiter #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 32,
    parameter int NB    = DW / 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_write,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic [NB-1:0] req0_mask,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_write,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    input  logic [NB-1:0] req1_mask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_rdata,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both high.
    // ready never depends on anything but state and the valids; valid/data hold until accepted.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          id_q, id_d;
    logic          write_q, write_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [NB-1:0] mask_q, mask_d;
    logic [DW-1:0] old_q, old_d;

    logic [DW-1:0] mem_q [DEPTH];
    logic          mem_we;
    logic [DW-1:0] bytemask;
    logic [DW-1:0] merged;
    logic          grant1;

`ifdef ARB_RR_EN
    logic ptr_q, ptr_d;

    always_comb grant1 = req1_valid & (~req0_valid | ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == RSP && rsp_ready) begin
            ptr_d = ~id_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb grant1 = req1_valid & ~req0_valid;
`endif

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            bytemask[8*i +: 8] = {8{mask_q[i]}};
        end
        merged = (old_q & ~bytemask) | (wdata_q & bytemask);
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mask_d     = mask_q;
        old_d      = old_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready = ~grant1;
                    req1_ready = grant1;
                    id_d       = grant1;
                    write_d    = grant1 ? req1_write : req0_write;
                    addr_d     = grant1 ? req1_addr  : req0_addr;
                    wdata_d    = grant1 ? req1_wdata : req0_wdata;
                    mask_d     = grant1 ? req1_mask  : req0_mask;
                    state_d    = RD;
                end
            end
            RD: begin
                old_d   = mem_q[addr_q];
                // An all-zero mask would rewrite the same word, so skip the write slot.
                state_d = (write_q && mask_q != '0) ? WR : RSP;
            end
            WR: begin
                mem_we  = 1'b1;
                state_d = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            old_q   <= old_d;
        end
    end

    // Contents survive reset; the write is qualified by state, which reset forces to IDLE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= merged;
        end
    end

    assign rsp_id    = id_q;
    assign rsp_rdata = old_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule
